// File: rtl/bus_io_bridge.sv
// bus_io_bridge: responder end of the CPU data bus. Decodes each full-word
// access to external DRAM or to the on-chip peripherals: LED register, 7-seg
// digit register with scan driver, free-running timer, and synchronized
// switches/buttons. Read data is combinational from Bus_addr. Writes commit
// on the rising cpu_clk edge.
//
// Ports:
//   cpu_clk, cpu_rst   clock, asynchronous active-high reset
//   Bus_addr/we/wdata  CPU request (byte address, write strobe, write data)
//   Bus_rdata          combinational read data
//   dram_addr/we/wdata DRAM request (word address), dram_rdata async DRAM data
//   sw, btn            raw asynchronous switches and buttons
//   led                LED register
//   dig_en, dig_seg    active-low digit enables and segments {A..G,DP}
module bus_io_bridge #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned TICK_DIV = 25000,
   parameter int unsigned DRAM_AW  = 14
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   input  logic [31:0]        Bus_addr,
   input  logic               Bus_we,
   input  logic [31:0]        Bus_wdata,
   output logic [31:0]        Bus_rdata,
   output logic [DRAM_AW-1:0] dram_addr,
   input  logic [31:0]        dram_rdata,
   output logic               dram_we,
   output logic [31:0]        dram_wdata,
   input  logic [23:0]        sw,
   input  logic [4:0]         btn,
   output logic [23:0]        led,
   output logic [7:0]         dig_en,
   output logic [7:0]         dig_seg
);

   localparam logic [31:0] IO_BASE  = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_DIG = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_TMR = 32'hFFFF_F020;
   localparam logic [31:0] ADDR_LED = 32'hFFFF_F060;
   localparam logic [31:0] ADDR_SW  = 32'hFFFF_F070;
   localparam logic [31:0] ADDR_BTN = 32'hFFFF_F078;

   localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_DIV - 1);

   logic [23:0]    led_q;
   logic [31:0]    dig_q;
   logic [31:0]    tmr_q;
   logic [TKW-1:0] pre_q;
   logic [SCW-1:0] scnt_q;
   logic [2:0]     idx_q;
   logic [23:0]    sw_meta_q,  sw_sync_q;
   logic [4:0]     btn_meta_q, btn_sync_q;

   logic dram_hit, dig_hit, tmr_hit, led_hit, sw_hit, btn_hit;
   logic wr_dig, wr_tmr, wr_led;
   logic [3:0] nib;

   // Address decode: everything below the IO page is DRAM, IO uses exact matches.
   assign dram_hit = (Bus_addr < IO_BASE);
   assign dig_hit  = (Bus_addr == ADDR_DIG);
   assign tmr_hit  = (Bus_addr == ADDR_TMR);
   assign led_hit  = (Bus_addr == ADDR_LED);
   assign sw_hit   = (Bus_addr == ADDR_SW);
   assign btn_hit  = (Bus_addr == ADDR_BTN);

   assign wr_dig = Bus_we & dig_hit;
   assign wr_tmr = Bus_we & tmr_hit;
   assign wr_led = Bus_we & led_hit;

   // DRAM port: gated by reset so a write in flight during reset never lands.
   assign dram_addr  = Bus_addr[DRAM_AW+1:2];
   assign dram_wdata = Bus_wdata;
   assign dram_we    = Bus_we & dram_hit & ~cpu_rst;

   // Read mux; unmapped IO addresses return zero.
   always_comb begin
      Bus_rdata = 32'h0;
      if (dram_hit)     Bus_rdata = dram_rdata;
      else if (dig_hit) Bus_rdata = dig_q;
      else if (tmr_hit) Bus_rdata = tmr_q;
      else if (led_hit) Bus_rdata = {8'h00, led_q};
      else if (sw_hit)  Bus_rdata = {8'h00, sw_sync_q};
      else if (btn_hit) Bus_rdata = {27'h0, btn_sync_q};
   end

   // Writable IO registers and input synchronizers.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         led_q      <= 24'h0;
         dig_q      <= 32'h0;
         sw_meta_q  <= 24'h0;
         sw_sync_q  <= 24'h0;
         btn_meta_q <= 5'h0;
         btn_sync_q <= 5'h0;
      end else begin
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         btn_meta_q <= btn;
         btn_sync_q <= btn_meta_q;
         if (wr_led) led_q <= Bus_wdata[23:0];
         if (wr_dig) dig_q <= Bus_wdata;
      end
   end

   // Timer: prescaler wrap bumps the count; a CPU write takes priority.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         pre_q <= '0;
         tmr_q <= 32'h0;
      end else if (wr_tmr) begin
         pre_q <= '0;
         tmr_q <= Bus_wdata;
      end else if (pre_q == TICK_LAST) begin
         pre_q <= '0;
         tmr_q <= tmr_q + 32'd1;
      end else begin
         pre_q <= pre_q + TKW'(1);
      end
   end

   // Digit scan: idx steps through the eight digits once per SCAN_DIV cycles.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         scnt_q <= '0;
         idx_q  <= 3'd0;
      end else if (scnt_q == SCAN_LAST) begin
         scnt_q <= '0;
         idx_q  <= idx_q + 3'd1;
      end else begin
         scnt_q <= scnt_q + SCW'(1);
      end
   end

   assign led    = led_q;
   assign dig_en = ~(8'b1 << idx_q);
   assign nib    = 4'(dig_q >> {idx_q, 2'b00});

   // Hex to active-low segments {A,B,C,D,E,F,G,DP}; DP held off.
   always_comb begin
      dig_seg = 8'hFF;
      case (nib)
         4'h0: dig_seg = 8'h03;
         4'h1: dig_seg = 8'h9F;
         4'h2: dig_seg = 8'h25;
         4'h3: dig_seg = 8'h0D;
         4'h4: dig_seg = 8'h99;
         4'h5: dig_seg = 8'h49;
         4'h6: dig_seg = 8'h41;
         4'h7: dig_seg = 8'h1F;
         4'h8: dig_seg = 8'h01;
         4'h9: dig_seg = 8'h09;
         4'hA: dig_seg = 8'h11;
         4'hB: dig_seg = 8'hC1;
         4'hC: dig_seg = 8'h63;
         4'hD: dig_seg = 8'h85;
         4'hE: dig_seg = 8'h61;
         4'hF: dig_seg = 8'h71;
         default: dig_seg = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_bus_io_bridge.sv
// Directed bench for bus_io_bridge with small scan/tick dividers.
module tb_bus_io_bridge;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] Bus_addr;
   logic        Bus_we;
   logic [31:0] Bus_wdata;
   logic [31:0] Bus_rdata;
   logic [13:0] dram_addr;
   logic [31:0] dram_rdata;
   logic        dram_we;
   logic [31:0] dram_wdata;
   logic [23:0] sw;
   logic [4:0]  btn;
   logic [23:0] led;
   logic [7:0]  dig_en;
   logic [7:0]  dig_seg;

   int total = 0;
   int bad   = 0;

   // Expected segment codes, digit value n in byte n.
   logic [63:0] seg_lo = 64'h1F41_4999_0D25_9F03;  // 7..0
   logic [63:0] seg_hi = 64'h7161_8563_C111_0901;  // F..8
   logic [63:0] en_tab = 64'h7FBF_DFEF_F7FB_FDFE;  // idx 7..0

   bus_io_bridge #(.SCAN_DIV(2), .TICK_DIV(4), .DRAM_AW(14)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .Bus_addr  (Bus_addr),
      .Bus_we    (Bus_we),
      .Bus_wdata (Bus_wdata),
      .Bus_rdata (Bus_rdata),
      .dram_addr (dram_addr),
      .dram_rdata(dram_rdata),
      .dram_we   (dram_we),
      .dram_wdata(dram_wdata),
      .sw        (sw),
      .btn       (btn),
      .led       (led),
      .dig_en    (dig_en),
      .dig_seg   (dig_seg)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Bus_addr  = a;
      Bus_wdata = d;
      Bus_we    = 1'b1;
      tick();
      Bus_we    = 1'b0;
   endtask

   initial begin
      cpu_rst    = 1'b1;
      Bus_addr   = 32'h0000_0010;
      Bus_we     = 1'b1;
      Bus_wdata  = 32'h1111_2222;
      dram_rdata = 32'h0;
      sw         = 24'h0;
      btn        = 5'h0;
      #1;
      // Reset state; a DRAM write strobe during reset stays blocked.
      chk("rst_dram_we", 32'(dram_we), 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_dig_en", 32'(dig_en), 32'hFE);
      chk("rst_dig_seg", 32'(dig_seg), 32'h03);
      Bus_we   = 1'b0;
      Bus_addr = 32'hFFFF_F020;
      #1;
      chk("rst_tmr", Bus_rdata, 32'h0);
      tick();
      cpu_rst = 1'b0;

      // 1: LED write and readback
      Bus_addr  = 32'hFFFF_F060;
      Bus_wdata = 32'h00A5_5A5A;
      Bus_we    = 1'b1;
      #1;
      chk("led_wr_dram_we", 32'(dram_we), 32'h0);
      tick();
      Bus_we = 1'b0;
      chk("led_q", 32'(led), 32'hA55A5A);
      chk("led_rd", Bus_rdata, 32'h00A5_5A5A);

      // 2: DRAM write, read, boundary addresses
      Bus_addr  = 32'h0000_0010;
      Bus_wdata = 32'hDEAD_BEEF;
      Bus_we    = 1'b1;
      #1;
      chk("dram_we", 32'(dram_we), 32'h1);
      chk("dram_addr", 32'(dram_addr), 32'h4);
      chk("dram_wdata", dram_wdata, 32'hDEAD_BEEF);
      tick();
      Bus_we     = 1'b0;
      dram_rdata = 32'hCAFE_F00D;
      #1;
      chk("dram_rd", Bus_rdata, 32'hCAFE_F00D);
      Bus_addr = 32'hFFFF_EFFC;
      Bus_we   = 1'b1;
      #1;
      chk("dram_top_we", 32'(dram_we), 32'h1);
      chk("dram_top_addr", 32'(dram_addr), 32'h3BFF);
      Bus_addr = 32'hFFFF_F000;
      #1;
      chk("io_base_no_dram_we", 32'(dram_we), 32'h0);
      Bus_we = 1'b0;

      // 3: switch/button synchronizers, SW write ignored
      Bus_addr = 32'hFFFF_F070;
      sw       = 24'h123456;
      tick();
      chk("sw_edge1", Bus_rdata, 32'h0);
      tick();
      chk("sw_edge2", Bus_rdata, 32'h0012_3456);
      Bus_wdata = 32'hFFFF_FFFF;
      Bus_we    = 1'b1;
      #1;
      chk("sw_wr_dram_we", 32'(dram_we), 32'h0);
      tick();
      Bus_we = 1'b0;
      chk("sw_wr_ignored", Bus_rdata, 32'h0012_3456);
      Bus_addr = 32'hFFFF_F078;
      btn      = 5'h15;
      tick();
      chk("btn_edge1", Bus_rdata, 32'h0);
      tick();
      chk("btn_edge2", Bus_rdata, 32'h15);

      // 4: timer wrap and write-beats-tick
      wr(32'hFFFF_F020, 32'hFFFF_FFFF);
      chk("tmr_load", Bus_rdata, 32'hFFFF_FFFF);
      repeat (3) tick();
      chk("tmr_pre3", Bus_rdata, 32'hFFFF_FFFF);
      tick();
      chk("tmr_wrap", Bus_rdata, 32'h0);
      repeat (3) tick();
      wr(32'hFFFF_F020, 32'h7);
      chk("tmr_wr_wins", Bus_rdata, 32'h7);
      repeat (3) tick();
      chk("tmr_hold7", Bus_rdata, 32'h7);
      tick();
      chk("tmr_inc8", Bus_rdata, 32'h8);

      // 5: digit scan from a fresh reset
      cpu_rst = 1'b1;
      #2;
      cpu_rst = 1'b0;
      wr(32'hFFFF_F000, 32'h0000_0008);
      chk("dig_rd", Bus_rdata, 32'h8);
      chk("scan0_en", 32'(dig_en), 32'hFE);
      chk("scan0_seg", 32'(dig_seg), 32'h01);
      tick();
      chk("scan1_en", 32'(dig_en), 32'hFD);
      chk("scan1_seg", 32'(dig_seg), 32'h03);
      repeat (2) tick();
      chk("scan2_en", 32'(dig_en), 32'hFB);
      repeat (12) tick();
      chk("scan_wrap_en", 32'(dig_en), 32'hFE);
      chk("scan_wrap_seg", 32'(dig_seg), 32'h01);
      wr(32'hFFFF_F000, 32'hFEDC_BA98);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("seg_hi_%0d", i), 32'(dig_seg), 32'(seg_hi[8*i +: 8]));
         chk($sformatf("en_hi_%0d", i), 32'(dig_en), 32'(en_tab[8*i +: 8]));
         repeat (2) tick();
      end
      wr(32'hFFFF_F000, 32'h7654_3210);
      for (int j = 0; j < 8; j++) begin
         int k;
         k = (j + 1) % 8;
         chk($sformatf("seg_lo_%0d", k), 32'(dig_seg), 32'(seg_lo[8*k +: 8]));
         chk($sformatf("en_lo_%0d", k), 32'(dig_en), 32'(en_tab[8*k +: 8]));
         repeat (2) tick();
      end

      // 6: reset during a LED write, then unmapped access
      wr(32'hFFFF_F060, 32'h0000_00FF);
      chk("led_pre_rst", 32'(led), 32'hFF);
      Bus_addr  = 32'hFFFF_F060;
      Bus_wdata = 32'h00AB_CDEF;
      Bus_we    = 1'b1;
      #3;
      cpu_rst = 1'b1;
      #1;
      chk("mid_rst_led", 32'(led), 32'h0);
      chk("mid_rst_dig_en", 32'(dig_en), 32'hFE);
      chk("mid_rst_dram_we", 32'(dram_we), 32'h0);
      tick();
      chk("rst_hold_led", 32'(led), 32'h0);
      cpu_rst = 1'b0;
      Bus_we  = 1'b0;
      tick();
      chk("led_write_lost", Bus_rdata, 32'h0);
      wr(32'hFFFF_F040, 32'h5A5A_5A5A);
      chk("unmapped_rd", Bus_rdata, 32'h0);
      chk("unmapped_no_led", 32'(led), 32'h0);
      Bus_addr = 32'hFFFF_F000;
      #1;
      chk("unmapped_no_dig", Bus_rdata, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
